// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Brief    : Shared types, constants and helpers for the display scan slice.
//  Revision : 1.0 - initial release
// ============================================================================

package display_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Width of an index able to address n digits.
    function automatic int digit_w(input int n);
        return $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/decodificador7seg.sv
`default_nettype none
// ============================================================================
//  Module   : decodificador7seg
//  Brief    : BCD to 7-segment decoder, active-high, seg_o = {a,b,c,d,e,f,g}.
//             Non-BCD codes 10..15 produce a dark digit.
//  Revision : 1.0 - initial release
// ============================================================================

module decodificador7seg (
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h00;
        case (bcd_i)
            4'd0:    seg_o = 7'b1111110;
            4'd1:    seg_o = 7'b0110000;
            4'd2:    seg_o = 7'b1101101;
            4'd3:    seg_o = 7'b1111001;
            4'd4:    seg_o = 7'b0110011;
            4'd5:    seg_o = 7'b1011011;
            4'd6:    seg_o = 7'b1011111;
            4'd7:    seg_o = 7'b1110000;
            4'd8:    seg_o = 7'b1111111;
            4'd9:    seg_o = 7'b1111011;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : display_scan_ctrl
//  Brief    : Time-multiplexed scan controller for N common-anode 7-segment
//             digits with inter-digit blanking and frame-aligned data updates.
//             Optional macro LEADING_ZERO_BLANK_EN darkens leading zeros.
//  Revision : 1.0 - initial release
// ============================================================================

module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [4*N_DIGITS-1:0]       digits_i,
    input  logic [N_DIGITS-1:0]         dp_i,
    input  logic                        load_i,
    output logic [7:0]                  seg_o,
    output logic [N_DIGITS-1:0]         an_o,
    output logic [$clog2(N_DIGITS)-1:0] digit_idx_o,
    output logic                        frame_o
);

    localparam int IDX_W  = digit_w(N_DIGITS);
    localparam int PS_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int PS_W   = $clog2(PS_MAX);

    localparam logic [PS_W-1:0]  SHOW_LAST  = PS_W'(CLK_DIV - 1);
    localparam logic [PS_W-1:0]  BLANK_LAST = PS_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    scan_state_t               state_q,    state_d;
    logic [PS_W-1:0]           ps_q,       ps_d;
    logic [IDX_W-1:0]          idx_q,      idx_d;
    logic                      first_q,    first_d;
    logic [4*N_DIGITS-1:0]     pend_dig_q, pend_dig_d;
    logic [N_DIGITS-1:0]       pend_dp_q,  pend_dp_d;
    logic [4*N_DIGITS-1:0]     act_dig_q,  act_dig_d;
    logic [N_DIGITS-1:0]       act_dp_q,   act_dp_d;
    logic [7:0]                seg_q,      seg_d;
    logic [N_DIGITS-1:0]       an_q,       an_d;
    logic                      frame_q,    frame_d;

    logic [3:0]                sel_nib;
    logic                      sel_dp;
    logic                      sel_lz;
    logic [6:0]                dec_seg;
    logic [N_DIGITS-1:0]       lz_mask;

    // ------------------------------------------------------------------------
    // Next-state: prescaler, scan FSM, pending/active frame registers
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ps_d       = ps_q;
        idx_d      = idx_q;
        first_d    = first_q;
        pend_dig_d = pend_dig_q;
        pend_dp_d  = pend_dp_q;
        act_dig_d  = act_dig_q;
        act_dp_d   = act_dp_q;
        frame_d    = 1'b0;

        if (load_i) begin
            pend_dig_d = digits_i;
            pend_dp_d  = dp_i;
        end

        case (state_q)
            SHOW: begin
                if (ps_q == SHOW_LAST) begin
                    state_d = BLANK;
                    ps_d    = '0;
                end else begin
                    ps_d = ps_q + 1'b1;
                end
            end
            BLANK: begin
                if (ps_q == BLANK_LAST) begin
                    state_d = SHOW;
                    ps_d    = '0;
                    first_d = 1'b0;
                    // The blank right after reset leads into digit 0, not digit 1.
                    if (!first_q && (idx_q != IDX_LAST)) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        idx_d = '0;
                    end
                    // Frame boundary: pending_d already folds in a coincident load.
                    if (idx_d == '0) begin
                        frame_d   = 1'b1;
                        act_dig_d = pend_dig_d;
                        act_dp_d  = pend_dp_d;
                    end
                end else begin
                    ps_d = ps_q + 1'b1;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Leading-zero mask over the frame that will be displayed next cycle
    // ------------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic upper_zero;
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (act_dig_d[4*k +: 4] == 4'h0);
            lz_mask[k] = upper_zero;
        end
    end
`else
    assign lz_mask = '0;
`endif

    // Outputs are registered, so select from next-state values to avoid lag.
    always_comb begin
        sel_nib = 4'h0;
        sel_dp  = 1'b0;
        sel_lz  = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                sel_nib = act_dig_d[4*k +: 4];
                sel_dp  = act_dp_d[k];
                sel_lz  = lz_mask[k];
            end
        end
    end

    decodificador7seg u_dec (
        .bcd_i (sel_nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        if (state_d == SHOW) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                an_d[k] = (idx_d != IDX_W'(k));
            end
            seg_d = {sel_dp, (sel_lz ? 7'h00 : dec_seg)};
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BLANK;
            ps_q       <= '0;
            idx_q      <= '0;
            first_q    <= 1'b1;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            act_dig_q  <= '0;
            act_dp_q   <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= '1;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ps_q       <= ps_d;
            idx_q      <= idx_d;
            first_q    <= first_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            act_dig_q  <= act_dig_d;
            act_dp_q   <= act_dp_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            frame_q    <= frame_d;
        end
    end

    assign seg_o       = seg_q;
    assign an_o        = an_q;
    assign digit_idx_o = idx_q;
    assign frame_o     = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_scan_ctrl
//  Brief    : Scoreboard bench for display_scan_ctrl (N=4, CLK_DIV=4, BLANK=2)
//             against a slot/frame timing model of the scan.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_display_scan_ctrl;

    localparam int N    = 4;
    localparam int CD   = 4;
    localparam int BL   = 2;
    localparam int SLOT = CD + BL;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        load_i   = 1'b0;
    logic [15:0] digits_i = 16'h0;
    logic [3:0]  dp_i     = 4'h0;
    logic [7:0]  seg_o;
    logic [3:0]  an_o;
    logic [1:0]  digit_idx_o;
    logic        frame_o;

    display_scan_ctrl #(
        .N_DIGITS     (N),
        .CLK_DIV      (CD),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits_i    (digits_i),
        .dp_i        (dp_i),
        .load_i      (load_i),
        .seg_o       (seg_o),
        .an_o        (an_o),
        .digit_idx_o (digit_idx_o),
        .frame_o     (frame_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [7:0] seg;
        logic [3:0] an;
        logic       frame;
        logic [1:0] idx;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          t     = 0;
    logic [6:0]  seg7 [16];
    logic [15:0] pend_dig = 16'h0;
    logic [15:0] disp_dig = 16'h0;
    logic [3:0]  pend_dp  = 4'h0;
    logic [3:0]  disp_dp  = 4'h0;

    // Cycle tt counts clocks since reset release (cycle 0 = first blank cycle).
    function automatic void slot_info(input int tt, output bit sh, output int dg,
                                      output int pos, output bit fb);
        int u;
        if (tt < BL) begin
            sh = 1'b0; dg = 0; pos = 0; fb = 1'b0;
        end else begin
            u   = tt - BL;
            dg  = (u / SLOT) % N;
            pos = u % SLOT;
            sh  = (pos < CD);
            fb  = sh && (pos == 0) && (dg == 0);
        end
    endfunction

    function automatic exp_t make_exp(input int tt);
        exp_t       e;
        bit         sh, fb, lz;
        int         dg, pos;
        logic [3:0] nib;
        slot_info(tt, sh, dg, pos, fb);
        e.t     = tt;
        e.frame = fb;
        e.idx   = 2'(dg);
        e.an    = 4'hF;
        e.seg   = 8'h00;
        if (sh) begin
            e.an = 4'hF & ~(4'b0001 << dg);
            nib  = 4'((disp_dig >> (4 * dg)) & 16'hF);
            lz   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            lz   = (dg > 0) && ((disp_dig >> (4 * dg)) == 16'h0);
`endif
            e.seg = {disp_dp[dg], (lz ? 7'h00 : seg7[nib])};
        end
        return e;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, queue expectation.
    task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] p);
        bit sh, fb;
        int dg, pos;
        load_i   = ld;
        digits_i = d;
        dp_i     = p;
        if (ld) begin
            pend_dig = d;
            pend_dp  = p;
        end
        slot_info(t + 1, sh, dg, pos, fb);
        if (fb) begin
            disp_dig = pend_dig;
            disp_dp  = pend_dp;
        end
        q.push_back(make_exp(t + 1));
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic rand_step();
        logic [15:0] d;
        logic [15:0] mask;
        case ($urandom_range(0, 3))
            0:       mask = 16'hFFFF;
            1:       mask = 16'h0FFF;
            2:       mask = 16'h00FF;
            default: mask = 16'h000F;
        endcase
        d = 16'($urandom) & mask;
        step(($urandom_range(0, 5) == 0), d, 4'($urandom));
    endtask

    task automatic mid_reset();
        bit sh, fb;
        int dg, pos;
        int guard;
        guard = 0;
        slot_info(t, sh, dg, pos, fb);
        while (!(sh && pos == 1 && dg != 0) && guard < 200) begin
            rand_step();
            slot_info(t, sh, dg, pos, fb);
            guard++;
        end
        load_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (an_o !== 4'hF || seg_o !== 8'h00 || frame_o !== 1'b0 || digit_idx_o !== 2'd0) begin
            fails++;
            $display("FAIL async_reset: seg_o=%b an_o=%b frame_o=%b idx=%0d, expected seg_o=00000000 an_o=1111 frame_o=0 idx=0",
                     seg_o, an_o, frame_o, digit_idx_o);
        end
        q.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        t        = 0;
        pend_dig = 16'h0;
        pend_dp  = 4'h0;
        disp_dig = 16'h0;
        disp_dp  = 4'h0;
        q.push_back(make_exp(0));
    endtask

    // Monitor: compares the DUT against the queued expectation for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].t == t) begin
                e = q.pop_front();
                tests++;
                if (seg_o !== e.seg || an_o !== e.an || frame_o !== e.frame || digit_idx_o !== e.idx) begin
                    fails++;
                    $display("FAIL scan cycle %0d: seg_o=%b an_o=%b frame_o=%b idx=%0d, expected seg_o=%b an_o=%b frame_o=%b idx=%0d",
                             e.t, seg_o, an_o, frame_o, digit_idx_o, e.seg, e.an, e.frame, e.idx);
                end
            end
        end
    end

    initial begin
        seg7[0]  = 7'b1111110; seg7[1]  = 7'b0110000; seg7[2]  = 7'b1101101;
        seg7[3]  = 7'b1111001; seg7[4]  = 7'b0110011; seg7[5]  = 7'b1011011;
        seg7[6]  = 7'b1011111; seg7[7]  = 7'b1110000; seg7[8]  = 7'b1111111;
        seg7[9]  = 7'b1111011;
        for (int i = 10; i < 16; i++) seg7[i] = 7'h00;

        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (an_o !== 4'hF || seg_o !== 8'h00 || frame_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: seg_o=%b an_o=%b frame_o=%b, expected 00000000 1111 0",
                     seg_o, an_o, frame_o);
        end
        rst_n = 1'b1;
        t     = 0;
        q.push_back(make_exp(0));

        // Directed frame: boundaries at cycles 2, 26, 50, 74, 98, 122.
        for (int i = 0; i < 150; i++) begin
            case (i)
                0:       step(1'b1, 16'h1234, 4'b0000);
                30:      step(1'b1, 16'h9999, 4'b0000);
                73:      step(1'b1, 16'h0008, 4'b0000);
                80:      step(1'b1, 16'h00A7, 4'b0010);
                110:     step(1'b1, 16'h0050, 4'b0000);
                default: step(1'b0, 16'($urandom), 4'($urandom));
            endcase
        end

        for (int i = 0; i < 600; i++) rand_step();
        mid_reset();
        for (int i = 0; i < 250; i++) rand_step();
        mid_reset();
        for (int i = 0; i < 60; i++) rand_step();

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one segment bus. It holds a frame of BCD nibbles, walks the digits at a programmable rate and drives each nibble through the team's BCD-to-7-segment decoder (decodificador7seg). It inserts a blanking gap between digits to prevent ghosting. It sits between the numeric datapath and the board display pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8); digit 0 = least significant.
CLK_DIV, 50000, clocks each digit is lit per slot (>=2).
BLANK_CYCLES, 16, clocks all anodes are off between slots (>=1).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
digits_i  in  4*N_DIGITS  BCD nibbles; nibble k = bits [4k+3:4k] = digit k.
dp_i  in  N_DIGITS  decimal-point request per digit, active-high.
load_i  in  1  one-cycle strobe: capture digits_i/dp_i into the pending register.
seg_o  out  8  {dp, a, b, c, d, e, f, g}, active-high; bits [6:0] come from the decoder.
an_o  out  N_DIGITS  anode enables, active-low, at most one bit low.
digit_idx_o  out  $clog2(N_DIGITS)  index of the current/next digit.
frame_o  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=BLANK, prescaler=0, digit_idx_o=0, an_o=all 1, seg_o=0, frame_o=0, pending/active registers=0.
- FSM has two states:
  - SHOW: an_o[idx]=0, other bits 1; seg_o={active_dp[idx], dec(active nibble idx)}; prescaler counts 0..CLK_DIV-1. At terminal count: go to BLANK, prescaler=0.
  - BLANK: an_o=all 1, seg_o=0; prescaler counts 0..BLANK_CYCLES-1. At terminal count: idx <= (idx==N_DIGITS-1) ? 0 : idx+1, go to SHOW.
- After reset, the first BLANK lasts BLANK_CYCLES, then digit 0 is shown. It is not incremented past 0 on that first exit.
- Output timing: seg_o and an_o are registered and updated in the same edge as the state register, so they reflect the current state with zero extra lag.
- Slot and frame length: slot = CLK_DIV+BLANK_CYCLES clocks; frame = N_DIGITS*slot clocks.
- Frame boundary: the BLANK-to-SHOW transition that enters idx 0, including the first one after reset.
  - frame_o pulses high for exactly that one cycle (the first SHOW cycle of digit 0).
  - On that edge: active <= pending.
- load_i: pending <= {dp_i, digits_i} on any cycle load_i is high.
  - If load_i coincides with the frame-boundary edge, active takes digits_i/dp_i directly, so new data is never delayed a full frame.
  - Display data therefore changes only at frame boundaries; a frame never shows torn data.
- Decoding: decoder output is active-high with segment a = bit 6. Nibbles 10..15 blank bits [6:0]; the dp bit is still driven from dp_i.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); the scan restarts from the first BLANK.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: during SHOW, a digit k>0 whose nibble is 0 and whose higher digits (k+1..N-1) are all 0 gets seg_o[6:0]=0. Digit 0 is never blanked. The dp bit and an_o are unaffected.
- Not defined: every digit is decoded as-is.

Decomposition:
- Package display_pkg holds:
  - typedef scan_state_t {BLANK, SHOW};
  - localparam SEG_BLANK=8'h00;
  - function digit_w(n) returning $clog2(n).
- Sub-module: decodificador7seg, instantiated once on the muxed nibble. Prescaler, FSM, registers and leading-zero logic stay in display_scan_ctrl.

Test Plan:
All scenarios use N_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=2.
1. Reset: assert rst_n=0 mid-SHOW -> same cycle an_o=4'b1111, seg_o=8'h00, frame_o=0. After release: 2 blank cycles, then frame_o=1 with an_o=4'b1110.
2. load_i with digits_i=16'h1234, dp_i=0 during the first blank:
   - digit 0: an_o=1110, seg_o=8'b00110011 for 4 cycles, then an_o=1111 for 2 cycles.
   - digit 1: an_o=1101, seg_o=8'b01111001.
   - digit 3 shows 8'b00110000.
   - frame_o repeats every 24 cycles.
3. digits_i=16'h00A7, dp_i=4'b0010 -> digit 0 seg_o=8'b01110000; digit 1 seg_o=8'b10000000 (blank + dp).
4. Mid-frame load_i of 16'h9999 while 16'h1234 is displayed -> remaining digits of the current frame still show 2,3,4 as appropriate; 9 (8'b01111011) appears only from the next frame_o.
5. load_i asserted in the frame_o cycle with 16'h0008 -> digit 0 in that same SHOW shows 8'b01111111.
6. With LEADING_ZERO_BLANK_EN, digits_i=16'h0050 -> digits 3 and 2 seg_o=0 with an_o still strobing, digit 1 '5' (8'b01011011), digit 0 '0' (8'b01111110). Without the macro, digits 3 and 2 show 8'b01111110.
